imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined immediate encoder: the inverse of the decode-stage immediate extender. Takes an immediate-format selector, a 32-bit immediate value and a 25-bit base field (instruction[31:7] holding rd/rs/funct bits). It scatters the immediate into the format's instruction bit positions and returns the merged field, plus an error flag when the value is not representable. Used by the self-test instruction generator and the trap/patch path; two registered stages with valid/ready flow control.

## Interface
- `CNT_W`, default 8: width of the saturating error counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept a request this cycle.
- `imm_src`  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 111 CSR uimm, 101/110 reserved.
- `imm`  in  32  immediate value.
- `base`  in  25  instruction[31:7] with non-immediate fields filled.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `field`  out  25  merged instruction[31:7].
- `err`  out  1  immediate not representable in the selected format.
- `err_cnt`  out  CNT_W  count of accepted-and-delivered results with `err`=1, saturating.

## Operation
- Bit placement (field bits ← imm bits); all other field bits are passed through from `base`:
  - I: [24:13]←[11:0].
  - S: [24:18]←[11:5]; [4:0]←[4:0].
  - B: [24]←[12]; [0]←[11]; [23:18]←[10:5]; [4:1]←[4:1].
  - J: [24]←[20]; [23:14]←[10:1]; [13]←[11]; [12:5]←[19:12].
  - U: [24:5]←[31:12].
  - CSR: [12:8]←[4:0].
- Representability checks (`err`=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - CSR: imm[31:5]=0.
- On error, `field` still carries the truncated placement.
- Reserved codes: `field`=`base`, `err`=1.
- Stage 1 registers the inputs and computes the check.
- Stage 2 registers the merged field and `err`.
- `err_cnt` increments on `out_valid && out_ready && err`. It holds at all-ones.

## Timing
- Reset values: `out_valid`=0, `field`=0, `err`=0, `err_cnt`=0. Both stage valid bits are 0.
- `in_ready`=1 from the first cycle after reset.
- Request accepted on `in_valid && in_ready`. The result appears with `out_valid`=1 exactly 2 cycles later when there is no backpressure.
- Throughput: 1 request per cycle.
- Each stage advances when it is empty or the downstream stage advances. `in_ready` = !s1_valid || s1_advance.
- Under backpressure, at most 2 requests are in flight. `in_ready` drops combinationally in the same cycle `out_ready`=0 with both stages full.
- While `out_valid`=1 and `out_ready`=0, `field`, `err` and `out_valid` hold stable.
- Reset asserted mid-operation: all in-flight requests are discarded. Outputs return to reset values on the next edge. No partial result is emitted.
- Reset has priority over every other event.

## Configuration
- `IMM_ENCODER_CSR_EN` defined: `imm_src`=111 encodes a CSR uimm as specified above.
- Not defined: 111 is treated as reserved (`field`=`base`, `err`=1). No CSR placement or check logic is built.

## Structure
- Shared package `imm_pkg`:
  - the `imm_src_t` enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_CSR);
  - field-width localparams: 25-bit field, 32-bit imm.
- The extender adopts the same package.
- One sub-module, `imm_encoder_core`: purely combinational placement and check. It is instantiated between the stage-1 and stage-2 registers. The pipeline and handshake logic stay in the top level.

## Test plan
- I-type, imm=0xFFFFFFFF, base=0 → field=0x1FFE000, err=0, `out_valid` 2 cycles after accept.
- J-type, imm=0x000FFFFE, base=0 → field=0x0FFFFE0, err=0. Same request with imm=0x000FFFFF → err=1, err_cnt=1.
- U-type, imm=0x12345000, base=0x000001F → field=0x02468BF, err=0. Same request with imm=0x12345001 → err=1.
- B-type back-to-back stream of 4 requests with `out_ready`=0 for 3 cycles mid-stream → no loss or duplication, order preserved, `in_ready` low while both stages are full.
- imm_src=111, imm=0x1F, base=0 → with macro: field=0x0001F00, err=0; without macro: field=0, err=1.
- `rst` pulsed with 2 requests in flight → `out_valid`=0 and err_cnt=0 the next cycle. A fresh request after reset completes with 2-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the immediate encoder and the decode-stage extender.
package imm_pkg;

   localparam int FIELD_W = 25;
   localparam int IMM_W   = 32;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_CSR = 3'b111
   } imm_src_t;

endpackage

// File: rtl/imm_encoder_core.sv
// Combinational scatter of an immediate into instruction[31:7] plus representability check.
// CSR uimm encoding is built only when IMM_ENCODER_CSR_EN is defined.
import imm_pkg::*;

module imm_encoder_core (
   input  logic [2:0]         imm_src,
   input  logic [IMM_W-1:0]   imm,
   input  logic [FIELD_W-1:0] base,
   output logic [FIELD_W-1:0] field,
   output logic               err
);

   // Field index = instruction bit - 7; bits not owned by the format come from base.
   always_comb begin
      field = base;
      err   = 1'b0;
      case (imm_src)
         IMM_I: begin
            field[24:13] = imm[11:0];
            err          = !((&imm[31:11]) || !(|imm[31:11]));
         end
         IMM_S: begin
            field[24:18] = imm[11:5];
            field[4:0]   = imm[4:0];
            err          = !((&imm[31:11]) || !(|imm[31:11]));
         end
         IMM_B: begin
            field[24]    = imm[12];
            field[0]     = imm[11];
            field[23:18] = imm[10:5];
            field[4:1]   = imm[4:1];
            err          = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         end
         IMM_J: begin
            field[24]    = imm[20];
            field[23:14] = imm[10:1];
            field[13]    = imm[11];
            field[12:5]  = imm[19:12];
            err          = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         end
         IMM_U: begin
            field[24:5] = imm[31:12];
            err         = |imm[11:0];
         end
`ifdef IMM_ENCODER_CSR_EN
         IMM_CSR: begin
            field[12:8] = imm[4:0];
            err         = |imm[31:5];
         end
`endif
         default: begin
            field = base;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined immediate encoder with valid/ready flow control and saturating error count.
// Define IMM_ENCODER_CSR_EN to enable the CSR uimm format (imm_src 111).
import imm_pkg::*;

module imm_encoder #(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         imm_src,
   input  logic [IMM_W-1:0]   imm,
   input  logic [FIELD_W-1:0] base,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIELD_W-1:0] field,
   output logic               err,
   output logic [CNT_W-1:0]   err_cnt
);

   logic               s1_valid;
   logic [2:0]         s1_src;
   logic [IMM_W-1:0]   s1_imm;
   logic [FIELD_W-1:0] s1_base;
   logic               s2_valid;
   logic               s1_advance;
   logic [FIELD_W-1:0] core_field;
   logic               core_err;

   // A stage may load when empty or when its contents move on this cycle.
   assign s1_advance = !s2_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;
   assign out_valid  = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_src   <= '0;
         s1_imm   <= '0;
         s1_base  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_src  <= imm_src;
            s1_imm  <= imm;
            s1_base <= base;
         end
      end
   end

   imm_encoder_core u_core (
      .imm_src (s1_src),
      .imm     (s1_imm),
      .base    (s1_base),
      .field   (core_field),
      .err     (core_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         field    <= '0;
         err      <= 1'b0;
      end else if (s1_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            field <= core_field;
            err   <= core_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (s2_valid && out_ready && err && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed, table-driven self-checking bench for imm_encoder.
module tb_imm_encoder;

   typedef struct {
      string       name;
      logic [2:0]  src;
      logic [31:0] imm;
      logic [24:0] base;
      logic [24:0] exp_field;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  imm_src;
   logic [31:0] imm;
   logic [24:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] field;
   logic        err;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;
   int model_cnt = 0;
   vec_t vecs[12];

   imm_encoder #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_src   (imm_src),
      .imm       (imm),
      .base      (base),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .field     (field),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Sends one request with out_ready high, then checks latency, result and error count.
   task automatic applyStimulus(input vec_t v);
      int lat;
      imm_src  = v.src;
      imm      = v.imm;
      base     = v.base;
      in_valid = 1'b1;
      out_ready = 1'b1;
      checkOutput({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      checkOutput({v.name, " latency"}, lat, 32'd2);
      checkOutput({v.name, " field"}, {7'd0, field}, {7'd0, v.exp_field});
      checkOutput({v.name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
      if (v.exp_err && model_cnt < 255) model_cnt++;
      step();
      checkOutput({v.name, " err_cnt"}, {24'd0, err_cnt}, model_cnt);
   endtask

   initial begin
      logic [24:0] exp_fields[4];
      logic [24:0] got_fields[4];
      int sent;
      int rcvd;
      bit low_seen;
      bit exp_rdy;

      vecs[0]  = '{"I_neg1",   3'b000, 32'hFFFF_FFFF, 25'h0000000, 25'h1FFE000, 1'b0};
      vecs[1]  = '{"J_ok",     3'b011, 32'h000F_FFFE, 25'h0000000, 25'h0FFFFE0, 1'b0};
      vecs[2]  = '{"J_odd",    3'b011, 32'h000F_FFFF, 25'h0000000, 25'h0FFFFE0, 1'b1};
      vecs[3]  = '{"U_ok",     3'b100, 32'h1234_5000, 25'h000001F, 25'h02468BF, 1'b0};
      vecs[4]  = '{"U_low",    3'b100, 32'h1234_5001, 25'h000001F, 25'h02468BF, 1'b1};
      vecs[5]  = '{"S_min",    3'b001, 32'hFFFF_F800, 25'h1FFFFFF, 25'h103FFE0, 1'b0};
      vecs[6]  = '{"B_ok",     3'b010, 32'h0000_0FFE, 25'h0000000, 25'h0FC001F, 1'b0};
      vecs[7]  = '{"B_range",  3'b010, 32'h0000_1000, 25'h0000000, 25'h1000000, 1'b1};
      vecs[8]  = '{"I_range",  3'b000, 32'h0000_0800, 25'h0001234, 25'h1001234, 1'b1};
      vecs[9]  = '{"rsv_101",  3'b101, 32'h0000_0000, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1};
`ifdef IMM_ENCODER_CSR_EN
      vecs[10] = '{"csr_uimm", 3'b111, 32'h0000_001F, 25'h0000000, 25'h0001F00, 1'b0};
      vecs[11] = '{"csr_wide", 3'b111, 32'h0000_0020, 25'h0000000, 25'h0000000, 1'b1};
`else
      vecs[10] = '{"csr_uimm", 3'b111, 32'h0000_001F, 25'h0000000, 25'h0000000, 1'b1};
      vecs[11] = '{"csr_wide", 3'b111, 32'h0000_0020, 25'h0000000, 25'h0000000, 1'b1};
`endif

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      imm_src = 3'b000;
      imm = '0;
      base = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst field", {7'd0, field}, 32'd0);
      checkOutput("rst err", {31'd0, err}, 32'd0);
      checkOutput("rst err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
      step();

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

      // Back-to-back B-type stream with a three-cycle stall on the output.
      for (int i = 0; i < 4; i++) exp_fields[i] = 25'(2 * (i + 1));
      sent = 0;
      rcvd = 0;
      low_seen = 1'b0;
      imm_src = 3'b010;
      base = '0;
      for (int c = 0; c < 40 && rcvd < 4; c++) begin
         out_ready = !(c >= 2 && c < 5);
         in_valid  = (sent < 4);
         imm       = 32'(2 * (sent + 1));
         #1;
         exp_rdy = ((sent - rcvd) < 2) || out_ready;
         checkOutput("stream in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         if (!in_ready) low_seen = 1'b1;
         if (out_valid && out_ready) begin
            if (rcvd < 4) got_fields[rcvd] = field;
            checkOutput("stream err", {31'd0, err}, 32'd0);
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream count", rcvd, 32'd4);
      checkOutput("stream stall seen", {31'd0, low_seen}, 32'd1);
      for (int i = 0; i < 4 && i < rcvd; i++)
         checkOutput("stream order", {7'd0, got_fields[i]}, {7'd0, exp_fields[i]});
      step();
      checkOutput("stream drained", {31'd0, out_valid}, 32'd0);

      // Reset with two erroring requests in flight.
      imm_src = 3'b101;
      in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_cnt = 0;
      checkOutput("midrst out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst err_cnt", {24'd0, err_cnt}, 32'd0);
      step();
      checkOutput("midrst no ghost", {31'd0, out_valid}, 32'd0);
      applyStimulus(vecs[0]);
      applyStimulus(vecs[2]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
